sqrt_result_collector: RTL
==========================

SQRT_RESULT_COLLECTOR -- requirements
Module: sqrt_result_collector

Interface
REQ-001 Parameter DEPTH, default 16, meaning result buffer entries and initial credit count; SHALL be a power of 2, at least 2.
REQ-002 Parameter DATA_W, default 32, meaning result word width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 up_vld  input  1  upstream has an argument set to issue.
REQ-006 up_rdy  output  1  credit available; upstream may issue this cycle.
REQ-007 issue_vld  output  1  drives the distributor arg_vld; combinational, equal to up_vld & up_rdy.
REQ-008 res_vld  input  1  result valid from the distributor; no backpressure possible.
REQ-009 res  input  DATA_W  result word from the distributor.
REQ-010 out_vld  output  1  buffered result available downstream.
REQ-011 out_rdy  input  1  downstream accepts.
REQ-012 out_data  output  DATA_W  oldest buffered result.
REQ-013 credits  output  $clog2(DEPTH+1)  current credit count, for observability.
REQ-014 overflow  output  1  sticky protocol-error flag.

Function
REQ-015 Issue event: up_vld & up_rdy. Pop event: out_vld & out_rdy. Push event: res_vld.
REQ-016 Credit counter:
- Issue without pop: decrements by 1.
- Pop without issue: increments by 1.
- Both in the same cycle: unchanged.
- Never exceeds DEPTH and never goes below 0.
REQ-017 up_rdy SHALL be 1 exactly when credits != 0; with credits == 0 and a pop in the same cycle, up_rdy stays 0 (no combinational credit bypass).
REQ-018 FIFO buffer:
- Circular; read and write pointers carry one extra wrap bit.
- Empty when the pointers are fully equal.
- Full when only the wrap bits differ.
- Both pointers wrap from DEPTH-1 to 0.
REQ-019 A push writes res at the write pointer and advances it.
REQ-020 A pop advances the read pointer.
REQ-021 Push and pop in the same cycle both take effect at any occupancy, including full and empty-plus-push.
REQ-022 out_vld SHALL equal !empty, and out_data SHALL show the entry at the read pointer.
REQ-023 Latency: res_vld in cycle N gives out_vld in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-024 Results leave in arrival order; data SHALL NOT be reordered or modified.
REQ-025 out_data SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-026 Invariant under legal upstream behaviour: credits + occupancy + in-flight issues = DEPTH.

Reset
REQ-027 On rst assertion, immediately and independent of clk:
- credits = DEPTH
- both pointers = 0
- out_vld = 0
- overflow = 0
REQ-028 out_data is don't-care while out_vld = 0.
REQ-029 Reset mid-operation discards all buffered and in-flight results. The distributor shares the same rst, so no stale res_vld arrives after release.
REQ-030 Buffer storage needs no reset.

Configuration
REQ-031 Macro SQRT_COLLECTOR_OVERFLOW_CHECK_EN, when defined:
- A push while full and not popping SHALL drop the word.
- Pointers SHALL be left unchanged.
- overflow SHALL set to 1 and hold until rst.
REQ-032 When the macro is not defined:
- overflow SHALL be tied to 0 and no check logic is built.
- A push while full is undefined behaviour.

Structure
REQ-033 Package sqrt_pipe_pkg SHALL hold:
- DATA_W = 32
- COLLECTOR_DEPTH = 16
- typedef data_t as logic [DATA_W-1:0]
REQ-034 Sub-module sqrt_result_fifo SHALL hold the storage, pointers and full/empty logic.
REQ-035 The top SHALL hold the credit counter, issue gating and overflow flag.

Verification
REQ-036 Reset: assert rst mid-stream -> credits = 16, out_vld = 0 and overflow = 0 in the same cycle, before any clk edge.
REQ-037 Credit exhaustion, DEPTH = 16: hold up_vld = 1, out_rdy = 0, return no results -> exactly 16 issue_vld pulses, then up_rdy = 0 and credits = 0.
REQ-038 Ordering: push 0x1, 0x2, 0x3 on consecutive cycles with out_rdy = 1 -> out_data 0x1, 0x2, 0x3 on the cycles after each push, and credits restored.
REQ-039 Simultaneous events: with credits = 5, issue and pop in the same cycle -> credits stays 5; with the FIFO full, push and pop together -> occupancy stays 16 and order is preserved.
REQ-040 Wrap-around: stream 40 results at random out_rdy -> all 40 values delivered in order, no loss, pointers wrapped twice.
REQ-041 Overflow, macro defined: force a 17th push while full and out_rdy = 0 -> word dropped, overflow = 1 and sticky. Macro undefined -> overflow stays 0.

Source files
------------

// File: rtl/sqrt_pipe_pkg.sv
// Shared constants and types for the square-root pipeline.
//
// Contents:
//   DATA_W          - result word width
//   COLLECTOR_DEPTH - result buffer entries (also the initial credit count)
//   data_t          - one result word
package sqrt_pipe_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned COLLECTOR_DEPTH = 16;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sqrt_result_fifo.sv
// Circular result buffer for the sqrt result collector.
//
// Pointers carry one extra wrap bit. The buffer is empty when the pointers are
// fully equal and full when only the wrap bits differ. Push and pop may occur
// in the same cycle at any occupancy. Storage is not reset.
//
// Ports:
//   clk     - clock, state updates on posedge
//   rst     - asynchronous active-high reset (pointers only)
//   push_i  - write data_i at the write pointer and advance it
//   data_i  - word to write
//   pop_i   - advance the read pointer (caller guarantees !empty_o)
//   data_o  - entry at the read pointer
//   empty_o - buffer empty
//   full_o  - buffer full
module sqrt_result_fifo
    import sqrt_pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = COLLECTOR_DEPTH,
    parameter int unsigned DATA_W = sqrt_pipe_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sqrt_result_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Power-of-2 depth makes the low bits wrap DEPTH-1 -> 0 on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sqrt_result_collector.sv
// Credit-gated result collector for the sqrt distributor.
//
// Upstream may issue an argument set only while a credit is held; each credit
// reserves one buffer slot for the eventual result, so the distributor never
// needs backpressure. A credit returns when downstream pops a result.
//
// Optional feature (macro SQRT_COLLECTOR_OVERFLOW_CHECK_EN):
//   defined   - a push while full and not popping is dropped and sets the
//               sticky overflow flag
//   undefined - overflow tied to 0, no check logic built
//
// Ports:
//   clk       - clock, state updates on posedge
//   rst       - asynchronous active-high reset
//   up_vld    - upstream has an argument set to issue
//   up_rdy    - credit available
//   issue_vld - issue strobe to the distributor (up_vld & up_rdy)
//   res_vld   - result valid from the distributor
//   res       - result word
//   out_vld   - buffered result available
//   out_rdy   - downstream accepts
//   out_data  - oldest buffered result
//   credits   - current credit count
//   overflow  - sticky protocol-error flag
module sqrt_result_collector
    import sqrt_pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = COLLECTOR_DEPTH,
    parameter int unsigned DATA_W = sqrt_pipe_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_vld,
    output logic                       up_rdy,
    output logic                       issue_vld,
    input  logic                       res_vld,
    input  logic [DATA_W-1:0]          res,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CreditMax = CW'(DEPTH);
    localparam logic [CW-1:0] CreditOne = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] credits_q, credits_d;
    logic          pop;
    logic          push_en;
    logic          fifo_empty;
    logic          fifo_full;

    // No bypass: a pop this cycle cannot grant a credit until next cycle.
    assign up_rdy    = (credits_q != '0);
    assign issue_vld = up_vld & up_rdy;
    assign out_vld   = ~fifo_empty;
    assign pop       = out_vld & out_rdy;
    assign credits   = credits_q;

    always_comb begin
        credits_d = credits_q;
        if (issue_vld && !pop) begin
            credits_d = credits_q - CreditOne;
        end else if (pop && !issue_vld && credits_q != CreditMax) begin
            credits_d = credits_q + CreditOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CreditMax;
        end else begin
            credits_q <= credits_d;
        end
    end

`ifdef SQRT_COLLECTOR_OVERFLOW_CHECK_EN
    logic drop;
    logic overflow_q, overflow_d;

    // A simultaneous pop frees a slot, so only an unmatched push is dropped.
    assign drop    = res_vld & fifo_full & ~pop;
    assign push_en = res_vld & ~drop;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign push_en  = res_vld;
    assign overflow = 1'b0;

    // Without the check, an unmatched push into a full buffer corrupts order.
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst) !(res_vld && fifo_full && !pop)
    );
`endif

    sqrt_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_en),
        .data_i  (res),
        .pop_i   (pop),
        .data_o  (out_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
